// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two DMEM requesters, the arbiter and the DMEM.
//   a_* / b_*      : requester side (req, we, lock, addr, wdata -> gnt, rvalid, rdata)
//   mem_*          : DMEM side (write, address, write_data -> read_data)
//   owner          : current bus owner, 00 none, 01 A, 10 B
// Modports: slave = arbiter, master = requesters plus DMEM environment.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              a_req;
  logic              a_we;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic [1:0]        owner;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    input  mem_read_data,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_write, mem_address, mem_write_data,
    output owner
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    output mem_read_data,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_write, mem_address, mem_write_data,
    input  owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port DMEM (comb read, posedge write) between
// port A (CPU) and port B (DMA/loader). One access per cycle, winner chosen
// combinationally; read data returned registered one cycle after the grant.
// A port may hold a bounded lock of up to MAX_LOCK consecutive locked grants.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (requester ports, DMEM ports, owner)
// Build option: define DMEM_ARB_RR_EN for round-robin conflict resolution
// (port that did not win last time wins); default is fixed priority to A.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W   = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  owner_e            owner_q, owner_d, win;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              fire, win_we, win_lock, sat;

`ifdef DMEM_ARB_RR_EN
  // Last winner history only matters for round-robin: 0 = A, 1 = B.
  logic              last_q, last_d;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      lock_cnt_q <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  // Winner selection and next-state logic.
  always_comb begin
    win        = OWN_NONE;
    owner_d    = OWN_NONE;
    lock_cnt_d = '0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    win_we     = 1'b0;
    win_lock   = 1'b0;
    sat        = (lock_cnt_q == CNT_MAX);
`ifdef DMEM_ARB_RR_EN
    last_d     = last_q;
`endif

    // Grants are held off while reset is asserted so no DMEM write can slip through.
    if (!rst_n) begin
      win = OWN_NONE;
    end else if (owner_q == OWN_A && bus.a_req && bus.a_lock && lock_cnt_q < CNT_MAX) begin
      win = OWN_A;
    end else if (owner_q == OWN_B && bus.b_req && bus.b_lock && lock_cnt_q < CNT_MAX) begin
      win = OWN_B;
    end else if (sat && owner_q == OWN_A && bus.b_req) begin
      win = OWN_B;                        // forced release of an exhausted lock
    end else if (sat && owner_q == OWN_B && bus.a_req) begin
      win = OWN_A;
    end else if (bus.a_req && bus.b_req) begin
`ifdef DMEM_ARB_RR_EN
      win = last_q ? OWN_A : OWN_B;
`else
      win = OWN_A;
`endif
    end else if (bus.a_req) begin
      win = OWN_A;
    end else if (bus.b_req) begin
      win = OWN_B;
    end

    fire = (win != OWN_NONE);
    if (win == OWN_A) begin
      win_we   = bus.a_we;
      win_lock = bus.a_lock;
    end else if (win == OWN_B) begin
      win_we   = bus.b_we;
      win_lock = bus.b_lock;
    end

    owner_d = win;
`ifdef DMEM_ARB_RR_EN
    if (fire) last_d = (win == OWN_B);
`endif

    // Counts locked grants, including the one that takes ownership.
    if (fire && win_lock) begin
      if (win == owner_q) lock_cnt_d = sat ? CNT_MAX : lock_cnt_q + CNT_W'(1);
      else                lock_cnt_d = CNT_W'(1);
    end

    // Read fire captures DMEM data at the posedge; writes leave rdata alone.
    if (win == OWN_A && !bus.a_we) begin
      a_rvalid_d = 1'b1;
      a_rdata_d  = bus.mem_read_data;
    end
    if (win == OWN_B && !bus.b_we) begin
      b_rvalid_d = 1'b1;
      b_rdata_d  = bus.mem_read_data;
    end
  end

  // DMEM drive and grants.
  assign bus.a_gnt          = bus.a_req & (win == OWN_A);
  assign bus.b_gnt          = bus.b_req & (win == OWN_B);
  assign bus.mem_write      = fire & win_we;
  assign bus.mem_address    = (win == OWN_A) ? bus.a_addr  :
                              (win == OWN_B) ? bus.b_addr  : '0;
  assign bus.mem_write_data = (win == OWN_A) ? bus.a_wdata :
                              (win == OWN_B) ? bus.b_wdata : '0;

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver checks grants and mem_write
// each cycle and queues expected read data; a monitor compares every
// rvalid/rdata against the queues. DMEM model: word idx i preloads 0xA0000000|i.
module tb_dmem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned ML = 8;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LOCK(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // DMEM model: combinational read, posedge write.
  logic [31:0] dmem [256];
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'hA000_0000 | 32'(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write) dmem[bus.mem_address[9:2]] <= bus.mem_write_data;
    end
  end
  assign bus.mem_read_data = dmem[bus.mem_address[9:2]];

  int checks   = 0;
  int failures = 0;
  logic [31:0] qa [$];
  logic [31:0] qb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic al,
                       input logic [31:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic bl,
                       input logic [31:0] ba, input logic [31:0] bd);
    bus.a_req = ar; bus.a_we = aw; bus.a_lock = al; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_lock = bl; bus.b_addr = ba; bus.b_wdata = bd;
  endtask

  // One cycle: check combinational grants at negedge, queue expected read data.
  task automatic cyc(input string tag, input logic ea, input logic eb,
                     input logic emw, input logic [31:0] ed);
    @(negedge clk);
    chk({tag, " a_gnt"},     32'(bus.a_gnt),     32'(ea));
    chk({tag, " b_gnt"},     32'(bus.b_gnt),     32'(eb));
    chk({tag, " mem_write"}, 32'(bus.mem_write), 32'(emw));
    if (ea && !bus.a_we) qa.push_back(ed);
    if (eb && !bus.b_we) qb.push_back(ed);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: registered read responses, one cycle after each read grant.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        chk("a_rvalid", 32'(bus.a_rvalid), 32'(qa.size() != 0));
        if (bus.a_rvalid && qa.size() != 0) chk("a_rdata", bus.a_rdata, qa.pop_front());
        else if (qa.size() != 0) void'(qa.pop_front());
        chk("b_rvalid", 32'(bus.b_rvalid), 32'(qb.size() != 0));
        if (bus.b_rvalid && qb.size() != 0) chk("b_rdata", bus.b_rdata, qb.pop_front());
        else if (qb.size() != 0) void'(qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a_wins;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst owner",    32'(bus.owner),     32'h0);
    chk("rst a_rvalid", 32'(bus.a_rvalid),  32'h0);
    chk("rst b_rvalid", 32'(bus.b_rvalid),  32'h0);
    chk("rst a_rdata",  bus.a_rdata,        32'h0);
    chk("rst b_rdata",  bus.b_rdata,        32'h0);
    chk("rst a_gnt",    32'(bus.a_gnt),     32'h0);
    chk("rst mem_write",32'(bus.mem_write), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: A write then A read of 0x10.
    drive(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc("t1 wr", 1, 0, 1, 0);
    chk("t1 owner", 32'(bus.owner), 32'h1);
    drive(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    cyc("t1 rd", 1, 0, 0, 32'hDEADBEEF);
    idle();
    cyc("t1 idle", 0, 0, 0, 0);
    chk("t1 owner idle", 32'(bus.owner), 32'h0);

    // B-only read so the round-robin history points at B.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h80, 0);
    cyc("tb rd", 0, 1, 0, 32'hA000_0020);
    chk("tb owner", 32'(bus.owner), 32'h2);

    // 2: simultaneous reads, no lock.
    for (int i = 0; i < 4; i++) begin
      a_wins = !RR || (i % 2 == 0);
      drive(1, 0, 0, 32'h40, 0, 1, 0, 0, 32'h80, 0);
      cyc("t2", a_wins, !a_wins, 0, a_wins ? 32'hA000_0010 : 32'hA000_0020);
    end
    idle();
    cyc("t2 idle", 0, 0, 0, 0);

    // 3: A locked for 12 cycles with B requesting: 8 A beats, B, then A again.
    for (int i = 0; i < 12; i++) begin
      a_wins = (i != 8);
      drive(1, 0, 1, 32'h40, 0, 1, 0, 0, 32'h80, 0);
      cyc("t3", a_wins, !a_wins, 0, a_wins ? 32'hA000_0010 : 32'hA000_0020);
    end
    idle();
    cyc("t3 idle", 0, 0, 0, 0);

    // 4: A locked 10 beats with B idle, then B arrives against the saturated lock.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0);
      cyc("t4", 1, 0, 0, 32'hA000_0011);
    end
    drive(1, 0, 1, 32'h44, 0, 1, 0, 0, 32'h84, 0);
    cyc("t4 release", 0, 1, 0, 32'hA000_0021);
    idle();
    cyc("t4 idle", 0, 0, 0, 0);

    // 5: B write 0x20, A reads it back the next cycle.
    drive(0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 32'h12345678);
    cyc("t5 wr", 0, 1, 1, 0);
    drive(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    cyc("t5 rd", 1, 0, 0, 32'h12345678);
    // Lock without request: nothing granted, owner drops.
    drive(0, 0, 1, 32'h20, 0, 0, 0, 1, 0, 0);
    cyc("lock noreq", 0, 0, 0, 0);
    chk("lock noreq owner", 32'(bus.owner), 32'h0);

    // 6: reset asserted just after a read fire.
    drive(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    cyc("t6 rd", 1, 0, 0, 32'hDEADBEEF);
    #2;
    drive(1, 1, 0, 32'h10, 32'h0BAD_0BAD, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6 a_rvalid",  32'(bus.a_rvalid),  32'h0);
    chk("t6 a_rdata",   bus.a_rdata,        32'h0);
    chk("t6 owner",     32'(bus.owner),     32'h0);
    chk("t6 mem_write", 32'(bus.mem_write), 32'h0);
    chk("t6 a_gnt",     32'(bus.a_gnt),     32'h0);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    // The write held during reset must not have landed.
    drive(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    cyc("t6 post rd", 1, 0, 0, 32'hDEADBEEF);
    idle();
    cyc("end idle", 0, 0, 0, 0);
    @(posedge clk); #2;

    chk("qa drained", 32'(qa.size()), 32'h0);
    chk("qb drained", 32'(qb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
